pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Collects stall requests from ID, EX (multi-cycle mul/div) and MEM (data-memory wait), plus exception flushes.
- Drives the hold vector consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and the flush/redirect to PC.
- Counts EX multi-cycle latency and MEM wait timeout internally.

Parameters:
ADDR_W, 32, width of redirect PC
EXCNT_W, 6, width of ex_cycles / EX countdown
MEM_TIMEOUT, 255, MEM wait cycles before forced bus-error flush (>=2)
EXC_VECTOR, 32'h0000_0080, redirect PC on MEM timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stallreq_id  in  1  ID load-use hazard, level
ex_start  in  1  EX begins multi-cycle op, 1-cycle pulse
ex_cycles  in  EXCNT_W  total EX latency of that op
mem_req  in  1  MEM stage accessing memory
mem_ack  in  1  memory data valid this cycle
flush_req  in  1  exception from MEM, level
flush_pc  in  ADDR_W  exception handler address
stall  out  6  hold: [0]PC [1]IF_ID [2]ID_EX [3]EX_MEM [4]MEM_WB [5]reserved (always 0)
flush  out  1  clear all pipeline regs this cycle
new_pc  out  ADDR_W  redirect target, valid when flush=1
ex_done  out  1  final EX stall cycle
mem_err  out  1  MEM timeout pulse
stall_cycles  out  32  count of cycles with stall[0]=1, saturating

Behaviour:
- rst=1 (sync): state RUN, ex_cnt=0, wait_cnt=0, stall_cycles=0. While rst=1, all combinational outputs are forced 0 (stall, flush, new_pc, ex_done, mem_err).
- FSM states: RUN, EX_BUSY. stall, flush, new_pc, ex_done and mem_err are combinational from state, counters and inputs (same-cycle).
- mem_stall = mem_req & ~mem_ack, valid in any state.
- Priority, highest first: timeout flush > flush_req > mem_stall > EX stall > stallreq_id.
- Timeout flush: wait_cnt==MEM_TIMEOUT-1 and mem_stall. Outputs flush=1, mem_err=1, new_pc=EXC_VECTOR, stall=0.
- flush_req: flush=1, new_pc=flush_pc, stall=0.
- Any flush (either source): next state RUN, ex_cnt=0, wait_cnt=0. A pending ex_start is discarded.
- mem_stall (no flush): stall=6'b011111. ex_cnt holds (EX frozen). wait_cnt increments.
- wait_cnt clears to 0 in any cycle with mem_stall=0.
- EX stall, entered from RUN on ex_start with N=ex_cycles:
  - N<=1: single stall cycle, stall=6'b001111, ex_done=1, stay RUN.
  - N>=2: start cycle stall=6'b001111, go EX_BUSY with ex_cnt=N-2.
- EX_BUSY: stall=6'b001111.
  - ex_cnt>0: decrement.
  - ex_cnt==0: ex_done=1, return to RUN next cycle.
  - Total EX stall = N cycles, ex_done in the last one.
- EX_BUSY frozen by mem_stall: neither decrement nor ex_done; ex_done is delayed by the freeze length.
- ex_start while in EX_BUSY: ignored.
- stallreq_id only (RUN, no other request): stall=6'b000111. stallreq_id during EX_BUSY is subsumed by the EX stall.
- No request: stall=0.
- stall_cycles: +1 each non-reset cycle with stall[0]=1; saturates at 32'hFFFF_FFFF; unaffected by flush.
- mem_ack arriving in the same cycle as mem_req: no stall. MEM_TIMEOUT wait yields exactly MEM_TIMEOUT-1 stalled cycles, then the flush cycle.

Test Plan:
- Reset, then stallreq_id=1 for 2 cycles -> stall=6'b000111 both cycles, then 0; stall_cycles=2.
- ex_start, ex_cycles=5 -> stall=6'b001111 for exactly 5 cycles, ex_done high only in the 5th; ex_cycles=0 -> 1 stall cycle with ex_done.
- ex_start, ex_cycles=4; 2 cycles later mem_req=1, mem_ack=0 for 3 cycles -> stall=6'b011111 for those 3 cycles; ex_done then arrives 3 cycles late (7 total stall cycles).
- mem_req held, mem_ack=0 with MEM_TIMEOUT=8 -> 7 cycles stall=6'b011111, 8th cycle flush=1, mem_err=1, new_pc=32'h80, stall=0.
- flush_req=1, flush_pc=32'h1000 during EX_BUSY together with stallreq_id -> same cycle flush=1, new_pc=32'h1000, stall=0; next cycle RUN, no ex_done.
- rst asserted mid EX_BUSY and mid MEM wait -> next cycle all outputs 0, stall_cycles=0, subsequent ex_start behaves from clean RUN.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall/flush request and hold-vector bundle for pipe_stall_ctrl
interface pipe_stall_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int EXCNT_W = 6
);
  logic               stallreq_id;
  logic               ex_start;
  logic [EXCNT_W-1:0] ex_cycles;
  logic               mem_req;
  logic               mem_ack;
  logic               flush_req;
  logic [ADDR_W-1:0]  flush_pc;
  logic [5:0]         stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               ex_done;
  logic               mem_err;
  logic [31:0]        stall_cycles;

  modport master (
    output stallreq_id, ex_start, ex_cycles, mem_req, mem_ack, flush_req, flush_pc,
    input  stall, flush, new_pc, ex_done, mem_err, stall_cycles
  );

  modport slave (
    input  stallreq_id, ex_start, ex_cycles, mem_req, mem_ack, flush_req, flush_pc,
    output stall, flush, new_pc, ex_done, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with EX latency and MEM timeout counters
module pipe_stall_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                EXCNT_W     = 6,
  parameter int                MEM_TIMEOUT = 255,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = 32'h0000_0080
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, EX_BUSY} state_t;

  state_t             state_q, state_d;
  logic [EXCNT_W-1:0] ex_cnt_q, ex_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]        stall_cycles_q, stall_cycles_d;

  logic              mem_stall;
  logic              timeout;
  logic [5:0]        stall_c;
  logic              flush_c;
  logic [ADDR_W-1:0] new_pc_c;
  logic              ex_done_c;
  logic              mem_err_c;

  assign mem_stall = bus.mem_req & ~bus.mem_ack;
  assign timeout   = mem_stall && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    ex_cnt_d   = ex_cnt_q;
    wait_cnt_d = '0;
    stall_c    = '0;
    flush_c    = 1'b0;
    new_pc_c   = '0;
    ex_done_c  = 1'b0;
    mem_err_c  = 1'b0;
    if (rst) begin
      state_d  = RUN;
      ex_cnt_d = '0;
    end else if (timeout) begin
      flush_c   = 1'b1;
      mem_err_c = 1'b1;
      new_pc_c  = EXC_VECTOR;
      state_d   = RUN;
      ex_cnt_d  = '0;
    end else if (bus.flush_req) begin
      flush_c  = 1'b1;
      new_pc_c = bus.flush_pc;
      state_d  = RUN;
      ex_cnt_d = '0;
    end else if (mem_stall) begin
      // EX is frozen underneath a memory wait: state and ex_cnt hold
      stall_c    = 6'b011111;
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else if (state_q == EX_BUSY) begin
      stall_c = 6'b001111;
      if (ex_cnt_q == '0) begin
        ex_done_c = 1'b1;
        state_d   = RUN;
      end else begin
        ex_cnt_d = ex_cnt_q - EXCNT_W'(1);
      end
    end else if (bus.ex_start) begin
      stall_c = 6'b001111;
      if (bus.ex_cycles <= EXCNT_W'(1)) begin
        ex_done_c = 1'b1;
      end else begin
        // start cycle plus the final ex_cnt==0 cycle account for two of the N
        state_d  = EX_BUSY;
        ex_cnt_d = bus.ex_cycles - EXCNT_W'(2);
      end
    end else if (bus.stallreq_id) begin
      stall_c = 6'b000111;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_c[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ex_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_cnt_q       <= ex_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.new_pc       = new_pc_c;
  assign bus.ex_done      = ex_done_c;
  assign bus.mem_err      = mem_err_c;
  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and random checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;
  localparam int          TO  = 8;
  localparam logic [31:0] EXC = 32'h0000_0080;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // model state: remaining EX stall cycles, consecutive MEM wait cycles, stall count
  int          m_rem;
  int          m_wait;
  logic [31:0] m_sc;

  pipe_stall_ctrl_if #(.ADDR_W(32), .EXCNT_W(6)) bus ();

  pipe_stall_ctrl #(
    .ADDR_W(32), .EXCNT_W(6), .MEM_TIMEOUT(TO), .EXC_VECTOR(EXC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    n_total++;
  endtask

  task automatic step(input logic r, input logic id, input logic es, input int ec,
                      input logic mq, input logic mk, input logic fr, input logic [31:0] fp);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done;
    logic        e_err;
    logic        ms;
    int          n;
    rst             = r;
    bus.stallreq_id = id;
    bus.ex_start    = es;
    bus.ex_cycles   = 6'(ec);
    bus.mem_req     = mq;
    bus.mem_ack     = mk;
    bus.flush_req   = fr;
    bus.flush_pc    = fp;
    @(negedge clk);
    e_stall = '0; e_flush = 1'b0; e_pc = '0; e_done = 1'b0; e_err = 1'b0;
    ms = mq & ~mk;
    if (r) begin
      m_rem = 0; m_wait = 0;
    end else if (ms && m_wait == TO - 1) begin
      e_flush = 1'b1; e_err = 1'b1; e_pc = EXC; m_rem = 0; m_wait = 0;
    end else if (fr) begin
      e_flush = 1'b1; e_pc = fp; m_rem = 0; m_wait = 0;
    end else if (ms) begin
      e_stall = 6'h1F; m_wait++;
    end else begin
      m_wait = 0;
      if (m_rem > 0) begin
        e_stall = 6'h0F; e_done = (m_rem == 1); m_rem--;
      end else if (es) begin
        n = (ec < 1) ? 1 : ec;
        e_stall = 6'h0F; e_done = (n == 1); m_rem = n - 1;
      end else if (id) begin
        e_stall = 6'h07;
      end
    end
    check("stall", bus.stall, e_stall);
    check("flush", bus.flush, e_flush);
    check("new_pc", bus.new_pc, e_pc);
    check("ex_done", bus.ex_done, e_done);
    check("mem_err", bus.mem_err, e_err);
    check("stall_cycles", bus.stall_cycles, m_sc);
    if (r) m_sc = '0;
    else if (e_stall[0] && m_sc != 32'hFFFF_FFFF) m_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic mq;
    n_pass = 0; n_total = 0;
    m_rem = 0; m_wait = 0; m_sc = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_sc", bus.stall_cycles, 0);

    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("id_sc", bus.stall_cycles, 2);

    step(0, 0, 1, 5, 0, 0, 0, 0);
    idle(6);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    step(0, 0, 1, 4, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(5);

    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
    #1;
    check("timeout_pc", bus.new_pc, 32'h80);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);

    step(0, 0, 1, 6, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 1, 32'h1000);
    idle(2);

    step(0, 0, 1, 10, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 3, 0, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 2, 0, 0, 0, 0);
    idle(3);

    mq = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) mq = ~mq;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 12)),
           mq, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
